apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 217 +++++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//
// Accepts read/write commands on a valid/ready interface, queues them in a
// 2-entry FIFO and executes them one at a time as APB transfers
// (IDLE -> SETUP -> ACCESS -> RESP). Each transfer produces a single
// response held on rsp_* until rsp_ready_i is seen.
//
// Optional feature (compile-time macro):
//   APB_CMD_MASTER_TIMEOUT_EN - ACCESS watchdog. A transfer that sees
//   TIMEOUT_CYCLES ACCESS cycles without pready_i is aborted with
//   rsp_err_o=1 and rsp_rdata_o=0. Without the macro ACCESS waits forever.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready = FIFO not full)
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i               command payload
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o, rsp_err_o    read data (0 for writes), PSLVERR/timeout flag
//   paddr_o, pwdata_o, pwrite_o,
//   psel_o, penable_o         APB requester outputs
//   prdata_i, pready_i,
//   pslverr_i                 APB completer inputs
//   busy_o                    FIFO non-empty or transfer/response in progress
// -----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic                      busy_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------------
  // Command FIFO (2 entries, pointer based so push and pop may coincide)
  // ---------------------------------------------------------------------------
  logic                      r_fifo_write [2];
  logic [APB_ADDR_WIDTH-1:0] r_fifo_addr  [2];
  logic [31:0]               r_fifo_wdata [2];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic w_push;
  logic w_pop;
  logic w_access_done;
  logic w_timeout;

  assign cmd_ready_o   = (r_count < 2'd2);
  assign w_push        = cmd_valid_i && cmd_ready_o;
  assign w_pop         = (r_state == ST_IDLE) && (r_count != 2'd0);
  assign w_access_done = (r_state == ST_ACCESS) && pready_i;

  // NOTE: the storage array is deliberately not reset; r_count alone says
  // which entries hold valid data, so resetting it would only cost flops.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_write[r_wr_ptr] <= cmd_write_i;
      r_fifo_addr[r_wr_ptr]  <= cmd_addr_i;
      r_fifo_wdata[r_wr_ptr] <= cmd_wdata_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ACCESS watchdog
  // ---------------------------------------------------------------------------
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wd_cnt;

  // Cleared in SETUP so it starts from zero on the first ACCESS cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= 8'd0;
    end else if (r_state == ST_SETUP) begin
      r_wd_cnt <= 8'd0;
    end else if ((r_state == ST_ACCESS) && !pready_i) begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end
  end

  // Fires on the ACCESS cycle whose increment would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_state == ST_ACCESS) && !pready_i && (r_wd_cnt == LP_WD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transfer and response registers
  // ---------------------------------------------------------------------------
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_pwrite;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_paddr     <= '0;
      r_pwdata    <= 32'h0;
      r_pwrite    <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Address/data/direction only change on a pop, so they stay stable
      // through SETUP and ACCESS.
      if (w_pop) begin
        r_paddr  <= r_fifo_addr[r_rd_ptr];
        r_pwdata <= r_fifo_wdata[r_rd_ptr];
        r_pwrite <= r_fifo_write[r_rd_ptr];
      end
      if (w_access_done) begin
        r_rsp_rdata <= r_pwrite ? 32'h0 : prdata_i;
        r_rsp_err   <= pslverr_i;
      end else if (w_timeout) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != 2'd0) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        psel_o      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign pwrite_o    = r_pwrite;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = (r_count != 2'd0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Self-checking bench for apb_cmd_master. A behavioural APB completer answers
// transfers; a transaction-level reference model (command queue + expected
// response queue) predicts FIFO occupancy, cmd_ready_o, busy_o, the APB
// sequencing rules and every response. Directed scenarios cover latency,
// wait states, FIFO full/back-pressure, slave error, watchdog/hang and reset,
// followed by a randomized phase.
// Honours APB_CMD_MASTER_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int AW = 12;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [31:0]   cmd_wdata_i = 32'h0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] paddr_o;
  logic [31:0]   pwdata_o;
  logic          pwrite_o;
  logic          psel_o;
  logic          penable_o;
  logic [31:0]   prdata_i = 32'h0;
  logic          pready_i = 1'b0;
  logic          pslverr_i = 1'b0;
  logic          busy_o;

  apb_cmd_master #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pwrite_o    (pwrite_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // ---------------------------------------------------------------------------
  // Behavioural APB completer: waits slv_wait ACCESS cycles, then answers.
  // ---------------------------------------------------------------------------
  logic        slv_rand  = 1'b0;
  logic        slv_hang  = 1'b0;
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err   = 1'b0;
  int          acc_cnt   = 0;

  always @(posedge clk_i) begin
    #1;
    if (psel_o && penable_o) begin
      pready_i  = !slv_hang && (acc_cnt >= slv_wait);
      prdata_i  = pready_i ? slv_rdata : $urandom;
      pslverr_i = pready_i ? slv_err : 1'b0;
      acc_cnt++;
    end else begin
      acc_cnt   = 0;
      // Junk outside ACCESS; the design must ignore it.
      pready_i  = 1'($urandom);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
      if (slv_rand && psel_o) begin
        slv_wait  = $urandom_range(0, 3);
        slv_rdata = $urandom;
        slv_err   = 1'($urandom);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model, evaluated mid-cycle when all signals are settled.
  // ---------------------------------------------------------------------------
  typedef struct { logic w; logic [AW-1:0] a; logic [31:0] d; } cmd_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  cmd_t fifo_q [$];
  rsp_t rsp_q  [$];
  cmd_t cur;
  logic have_cur = 1'b0;
  logic exp_setup = 1'b0, exp_access = 1'b0, exp_hold = 1'b0;
  logic exp_resp = 1'b0, exp_idle = 1'b0, prev_rsp = 1'b0;
  int   acc_wait = 0;
  int   pen_cnt = 0, n_xfer = 0, n_rsp = 0;
  int   push_cyc = 0, setup_cyc = 0, access_cyc = 0, rspv_cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      fifo_q.delete();
      rsp_q.delete();
      have_cur = 1'b0;
      exp_setup = 1'b0; exp_access = 1'b0; exp_hold = 1'b0;
      exp_resp = 1'b0; exp_idle = 1'b0; prev_rsp = 1'b0;
      acc_wait = 0;
    end else begin
      if (exp_setup)  check("idle_to_setup", 64'({psel_o, penable_o}), 64'(2'b10));
      if (exp_access) check("setup_to_access", 64'({psel_o, penable_o}), 64'(2'b11));
      if (exp_hold)   check("access_hold", 64'({psel_o, penable_o, rsp_valid_o}), 64'(3'b110));
      if (exp_resp)   check("access_to_resp", 64'({psel_o, penable_o, rsp_valid_o}), 64'(3'b001));
      if (exp_idle)   check("resp_to_idle", 64'({psel_o, rsp_valid_o}), 64'(2'b00));
      check("penable_without_psel", 64'(penable_o && !psel_o), 64'(0));
      check("psel_while_rsp", 64'(psel_o && rsp_valid_o), 64'(0));

      // First SETUP cycle: the head command has just left the FIFO.
      if (psel_o && !penable_o) begin
        check("setup_has_cmd", 64'(fifo_q.size() != 0), 64'(1));
        if (fifo_q.size() != 0) begin
          cur = fifo_q.pop_front();
          have_cur = 1'b1;
        end
        setup_cyc = cyc;
        pen_cnt   = 0;
        acc_wait  = 0;
        n_xfer++;
      end
      if (psel_o && have_cur) begin
        check("paddr", 64'(paddr_o), 64'(cur.a));
        check("pwrite", 64'(pwrite_o), 64'(cur.w));
        check("pwdata", 64'(pwdata_o), 64'(cur.d));
      end
      if (psel_o && penable_o) begin
        if (pen_cnt == 0) access_cyc = cyc;
        pen_cnt++;
      end

      if (rsp_valid_o) begin
        if (!prev_rsp) rspv_cyc = cyc;
        check("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
        if (rsp_q.size() != 0) begin
          check("rsp_rdata", 64'(rsp_rdata_o), 64'(rsp_q[0].rdata));
          check("rsp_err", 64'(rsp_err_o), 64'(rsp_q[0].err));
          if (rsp_ready_i) begin
            last_rdata = rsp_rdata_o;
            last_err   = rsp_err_o;
            void'(rsp_q.pop_front());
            n_rsp++;
          end
        end
      end

      check("busy", 64'(busy_o), 64'(fifo_q.size() != 0 || psel_o || rsp_valid_o));
      check("cmd_ready", 64'(cmd_ready_o), 64'(fifo_q.size() < 2));

      // Predictions for the next cycle.
      exp_setup  = !psel_o && !rsp_valid_o && (fifo_q.size() != 0);
      exp_access = psel_o && !penable_o;
      exp_hold   = 1'b0;
      exp_resp   = 1'b0;
      if (psel_o && penable_o) begin
        if (pready_i) begin
          rsp_q.push_back('{cur.w ? 32'h0 : prdata_i, pslverr_i});
          exp_resp = 1'b1;
        end else begin
          acc_wait++;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          if (acc_wait == TO) begin
            rsp_q.push_back('{32'h0, 1'b1});
            exp_resp = 1'b1;
          end else begin
            exp_hold = 1'b1;
          end
`else
          exp_hold = 1'b1;
`endif
        end
      end
      exp_idle = rsp_valid_o && rsp_ready_i;
      prev_rsp = rsp_valid_o;

      if (cmd_valid_i && cmd_ready_o) begin
        fifo_q.push_back('{cmd_write_i, cmd_addr_i, cmd_wdata_i});
        push_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left 1 ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    @(negedge clk_i);
    while (!cmd_ready_o && t < 50) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      t++;
    end
    check("send_accepted", 64'(cmd_ready_o), 64'(1));
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (n_rsp < target && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("rsp_arrived", 64'(n_rsp >= target), 64'(1));
  endtask

  task automatic wait_access();
    int t;
    t = 0;
    while (!(psel_o && penable_o) && t < 20) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("reach_access", 64'({psel_o, penable_o}), 64'(2'b11));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base_x;
  int base_r;

  initial begin
    // ---- reset values ----
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ctrl", 64'({psel_o, penable_o, rsp_valid_o, busy_o, pwrite_o, rsp_err_o}), 64'(0));
    check("rst_paddr", 64'(paddr_o), 64'(0));
    check("rst_pwdata", 64'(pwdata_o), 64'(0));
    check("rst_rdata", 64'(rsp_rdata_o), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // ---- zero-wait write: latency N+2 / N+3 / N+4 ----
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
    base_r = n_rsp;
    send(1'b1, 12'h004, 32'hA5A5_0001);
    wait_rsp(base_r + 1);
    check("lat_setup", 64'(setup_cyc - push_cyc), 64'(2));
    check("lat_access", 64'(access_cyc - push_cyc), 64'(3));
    check("lat_rsp", 64'(rspv_cyc - push_cyc), 64'(4));
    check("wr_err", 64'(last_err), 64'(0));
    check("wr_rdata", 64'(last_rdata), 64'(0));

    // ---- read with 3 wait states ----
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    base_r = n_rsp;
    send(1'b0, 12'h010, 32'h0BAD_F00D);
    wait_rsp(base_r + 1);
    check("rd_rdata", 64'(last_rdata), 64'(32'h1234_5678));
    check("rd_penable_cycles", 64'(pen_cnt), 64'(4));

    // ---- three back-to-back commands under response back-pressure ----
    slv_wait = 0;
    rsp_ready_i = 1'b0;
    base_x = n_xfer;
    base_r = n_rsp;
    send(1'b1, 12'h100, 32'h1111_1111);
    send(1'b1, 12'h104, 32'h2222_2222);
    send(1'b1, 12'h108, 32'h3333_3333);
    repeat (6) @(posedge clk_i);
    #1;
    check("full_cmd_ready", 64'(cmd_ready_o), 64'(0));
    check("full_rsp_hold", 64'(rsp_valid_o), 64'(1));
    check("full_one_xfer", 64'(n_xfer - base_x), 64'(1));
    check("full_no_rsp", 64'(n_rsp - base_r), 64'(0));
    rsp_ready_i = 1'b1;
    wait_rsp(base_r + 3);
    check("full_all_xfer", 64'(n_xfer - base_x), 64'(3));

    // ---- slave error, then a clean command ----
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'hCAFE_0000;
    base_r = n_rsp;
    send(1'b0, 12'h200, 32'h0);
    wait_rsp(base_r + 1);
    check("slverr_err", 64'(last_err), 64'(1));
    slv_err = 1'b0; slv_rdata = 32'h0000_CAFE;
    send(1'b0, 12'h204, 32'h0);
    wait_rsp(base_r + 2);
    check("after_err_err", 64'(last_err), 64'(0));
    check("after_err_rdata", 64'(last_rdata), 64'(32'h0000_CAFE));

    // ---- completer never ready ----
    slv_hang = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    base_r = n_rsp;
    send(1'b0, 12'h300, 32'h0);
    wait_rsp(base_r + 1);
    check("to_err", 64'(last_err), 64'(1));
    check("to_rdata", 64'(last_rdata), 64'(0));
    check("to_cycles", 64'(pen_cnt), 64'(TO));
`endif
    send(1'b0, 12'h310, 32'h0);
    wait_access();
`ifndef APB_CMD_MASTER_TIMEOUT_EN
    repeat (100) @(posedge clk_i);
    #1;
    check("hang_persists", 64'({psel_o, penable_o, rsp_valid_o}), 64'(3'b110));
`endif

    // ---- asynchronous reset mid-ACCESS ----
    base_r = n_rsp;
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid_psel_pen", 64'({psel_o, penable_o}), 64'(0));
    check("rst_mid_busy", 64'(busy_o), 64'(0));
    check("rst_mid_ready", 64'(cmd_ready_o), 64'(1));
    check("rst_mid_rsp", 64'(rsp_valid_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    slv_hang = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    check("rst_no_rsp", 64'(n_rsp - base_r), 64'(0));
    check("rst_idle_busy", 64'(busy_o), 64'(0));

    // ---- randomized traffic ----
    slv_rand = 1'b1;
    base_r = n_rsp;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid_i = 1'($urandom);
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = AW'($urandom);
      cmd_wdata_i = $urandom;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check("rand_progress", 64'(n_rsp - base_r > 200), 64'(1));
    check("rand_drained", 64'(busy_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
